// File: rtl/rib_pkg.sv
// Shared definitions for the RIB bus RAM slave: FSM states, request constants,
// byte-strobe constants and the latched request payload.
package rib_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic RIB_REQ  = 1'b1;
    localparam logic RIB_NREQ = 1'b0;

    localparam logic [SEL_W-1:0] SEL_NONE = 4'b0000;
    localparam logic [SEL_W-1:0] SEL_B0   = 4'b0001;
    localparam logic [SEL_W-1:0] SEL_B1   = 4'b0010;
    localparam logic [SEL_W-1:0] SEL_B2   = 4'b0100;
    localparam logic [SEL_W-1:0] SEL_B3   = 4'b1000;
    localparam logic [SEL_W-1:0] SEL_HALF_LO = 4'b0011;
    localparam logic [SEL_W-1:0] SEL_HALF_HI = 4'b1100;
    localparam logic [SEL_W-1:0] SEL_WORD = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_MERGE,
        ST_RESP
    } rib_state_e;

    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] wdata;
    } rib_payload_t;

    // Replace the strobed byte lanes of old_word with those of new_word.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [SEL_W-1:0]  sel
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < int'(SEL_W); b++) begin
            if (sel[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rib_ram_sp.sv
// Single-port word RAM with synchronous one-cycle read and per-byte write enables.
// Contents are never reset; rdata only changes on a read.
module rib_ram_sp #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          re,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/rib_ram_slave.sv
// RIB bus slave in front of a single-port RAM with optional wait states.
// Define RIB_RAM_BYTE_WE_EN to write partial words through byte enables instead of read-merge-write.
module rib_ram_slave
    import rib_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  sel_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    rib_state_e   state, next_state;
    rib_payload_t lat_q;
    logic [AW-1:0] widx_q;
    logic          oor_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic          lat_en;
    logic          oor_in;
    logic          use_in_addr;
    logic          ram_re, ram_re_g;
    logic [3:0]    ram_we, ram_we_g;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^addr_i[1:0];
    assign oor_in = ({2'b00, addr_i[31:2]} >= DEPTH_WORDS);

    // State, payload latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt_q   <= '0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            state <= next_state;
            cnt_q <= cnt_d;
            ack_o <= (next_state == ST_RESP);
            err_o <= (next_state == ST_RESP) && oor_q;
            if (next_state == ST_RESP) begin
                if (oor_q)          rdata_o <= '0;
                else if (!lat_q.we) rdata_o <= ram_rdata;
            end
        end
        if (lat_en) begin
            lat_q  <= '{we: we_i, sel: sel_i, wdata: wdata_i};
            widx_q <= addr_i[AW+1:2];
            oor_q  <= oor_in;
        end
    end

    // The RAM read is launched on the edge entering ACCESS so its word is
    // available during ACCESS/MERGE and can be registered into rdata_o for RESP.
    always_comb begin
        next_state  = state;
        cnt_d       = cnt_q;
        lat_en      = 1'b0;
        use_in_addr = 1'b0;
        ram_re      = 1'b0;
        ram_we      = '0;
        ram_wdata   = lat_q.wdata;
        case (state)
            ST_IDLE: begin
                if (req_i == RIB_REQ) begin
                    lat_en = 1'b1;
                    cnt_d  = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        next_state  = ST_ACCESS;
                        ram_re      = 1'b1;
                        use_in_addr = 1'b1;
                    end else begin
                        next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    next_state = ST_ACCESS;
                    ram_re     = 1'b1;
                end
            end
            ST_ACCESS: begin
                next_state = ST_RESP;
                if (lat_q.we && !oor_q) begin
`ifdef RIB_RAM_BYTE_WE_EN
                    ram_we = lat_q.sel;
`else
                    if (lat_q.sel == SEL_WORD)      ram_we = SEL_WORD;
                    else if (lat_q.sel != SEL_NONE) next_state = ST_MERGE;
`endif
                end
            end
            ST_MERGE: begin
                ram_we     = SEL_WORD;
                ram_wdata  = merge_lanes(ram_rdata, lat_q.wdata, lat_q.sel);
                next_state = ST_RESP;
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Reset blocks any RAM access launched in the same cycle.
    assign ram_re_g = ram_re & ~rst;
    assign ram_we_g = ram_we & {4{~rst}};
    assign ram_addr = use_in_addr ? addr_i[AW+1:2] : widx_q;

    rib_ram_sp #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .re   (ram_re_g),
        .we   (ram_we_g),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_rib_ram_slave.sv
// Self-checking bench for rib_ram_slave: three configurations (no wait, 3 waits, 16 words)
// driven from a shared clock, checked against a word model through an expectation queue.
module tb_rib_ram_slave;

`ifdef RIB_RAM_BYTE_WE_EN
    localparam bit BYTE_WE = 1'b1;
`else
    localparam bit BYTE_WE = 1'b0;
`endif

    typedef struct {
        int          k;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        bit          rel;
    } op_t;

    typedef struct {
        int          lat;
        logic [31:0] rd;
        logic        er;
    } exp_t;

    typedef struct {
        int          lat;
        logic [31:0] rd;
        logic        er;
        bit          pulse_ok;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  sel   [3];
    logic        ack   [3];
    logic [31:0] rdata [3];
    logic        err   [3];

    int n_assert = 0;
    int n_fail   = 0;

    exp_t        sb[$];
    logic [31:0] model[int];
    logic [31:0] last_rd[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rib_ram_slave #(.DEPTH_WORDS(4096), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .sel_i(sel[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0]));

    rib_ram_slave #(.DEPTH_WORDS(4096), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .sel_i(sel[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1]));

    rib_ram_slave #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_d16 (
        .clk(clk), .rst(rst), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]),
        .wdata_i(wdata[2]), .sel_i(sel[2]), .ack_o(ack[2]), .rdata_o(rdata[2]), .err_o(err[2]));

    function automatic int wait_of(input int k);
        return (k == 1) ? 3 : 0;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 2) ? 16 : 4096;
    endfunction

    // Compute the expected response from the word model, then update the model.
    task automatic push_expect(input op_t o);
        exp_t        e;
        int          widx;
        int          key;
        bit          oor;
        bit          merge;
        logic [31:0] cur;
        widx  = int'(o.a[31:2]);
        oor   = (o.a[31:2] >= 30'(depth_of(o.k)));
        key   = o.k * (1 << 20) + widx;
        merge = o.w && !oor && !BYTE_WE && (o.s != 4'b0000) && (o.s != 4'b1111);
        e.lat = wait_of(o.k) + 2 + (merge ? 1 : 0);
        e.er  = oor;
        if (oor) begin
            e.rd = 32'h0;
            last_rd[o.k] = 32'h0;
        end else if (!o.w) begin
            e.rd = model.exists(key) ? model[key] : 32'hxxxx_xxxx;
            last_rd[o.k] = e.rd;
        end else begin
            e.rd = last_rd[o.k];
            cur  = model.exists(key) ? model[key] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (o.s[b]) cur[8*b +: 8] = o.d[8*b +: 8];
            end
            model[key] = cur;
        end
        sb.push_back(e);
    endtask

    // Drive one transaction; payload is scrambled after the latch cycle to show it is ignored.
    task automatic run_txn(input op_t o, output obs_t ob);
        @(posedge clk);
        #1;
        req[o.k] = 1'b1; we[o.k] = o.w; addr[o.k] = o.a; wdata[o.k] = o.d; sel[o.k] = o.s;
        ob.lat = -1; ob.rd = 'x; ob.er = 'x; ob.pulse_ok = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (ack[o.k] === 1'b1) begin
                ob.lat = c; ob.rd = rdata[o.k]; ob.er = err[o.k];
                break;
            end
            if (c == 0) begin
                @(posedge clk);
                #1;
                we[o.k] = ~o.w; addr[o.k] = o.a ^ 32'h100; wdata[o.k] = ~o.d; sel[o.k] = ~o.s;
            end
        end
        if (o.rel || ob.lat < 0) begin
            @(posedge clk);
            #1;
            req[o.k] = 1'b0;
            @(negedge clk);
            ob.pulse_ok = (ack[o.k] === 1'b0);
        end
    endtask

    task automatic drive_op(input op_t o, output obs_t ob);
        push_expect(o);
        run_txn(o, ob);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (ack[k] !== 1'b0 || err[k] !== 1'b0 || rdata[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset k=%0d: ack=%b err=%b rdata=%h, expected 0/0/00000000",
                         k, ack[k], err[k], rdata[k]);
            end
            last_rd[k] = 32'h0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_ops(input string name, input op_t ops[$]);
        obs_t ob;
        exp_t e;
        foreach (ops[i]) begin
            drive_op(ops[i], ob);
            e = sb.pop_front();
            n_assert++;
            if (ob.lat !== e.lat || ob.rd !== e.rd || ob.er !== e.er || !ob.pulse_ok) begin
                n_fail++;
                $display("FAIL %s op%0d k=%0d addr=%h: lat=%0d rdata=%h err=%b pulse_ok=%0b, expected lat=%0d rdata=%h err=%b pulse_ok=1",
                         name, i, ops[i].k, ops[i].a, ob.lat, ob.rd, ob.er, ob.pulse_ok, e.lat, e.rd, e.er);
            end
        end
    endtask

    task automatic test_full_word;
        op_t ops[$];
        ops.push_back('{0, 1'b1, 32'h40, 32'h1234_5678, 4'b1111, 1'b1});
        ops.push_back('{0, 1'b0, 32'h40, 32'h0, 4'b1111, 1'b1});
        test_ops("full_word", ops);
    endtask

    task automatic test_partial;
        op_t  ops[$];
        obs_t ob;
        exp_t e;
        ops.push_back('{0, 1'b1, 32'h40, 32'h0000_AB00, 4'b0010, 1'b1});
        ops.push_back('{0, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, 1'b1});
        test_ops("partial", ops);
        drive_op('{0, 1'b0, 32'h40, 32'h0, 4'b1111, 1'b1}, ob);
        e = sb.pop_front();
        n_assert++;
        if (ob.rd !== 32'h1234_AB78 || ob.lat !== 2) begin
            n_fail++;
            $display("FAIL partial_read: rdata=%h lat=%0d, expected 1234ab78 lat=2 (model %h)",
                     ob.rd, ob.lat, e.rd);
        end
    endtask

    task automatic test_wait;
        op_t ops[$];
        ops.push_back('{1, 1'b1, 32'h0, 32'hDEAD_BEEF, 4'b1111, 1'b1});
        ops.push_back('{1, 1'b0, 32'h0, 32'h0, 4'b1111, 1'b1});
        ops.push_back('{1, 1'b1, 32'h0, 32'h5500_0000, 4'b1000, 1'b1});
        ops.push_back('{1, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1});
        test_ops("wait3", ops);
    endtask

    task automatic test_out_of_range;
        op_t ops[$];
        ops.push_back('{2, 1'b1, 32'h0,  32'hCAFE_F00D, 4'b1111, 1'b1});
        ops.push_back('{2, 1'b1, 32'h3C, 32'h1122_3344, 4'b1111, 1'b1});
        ops.push_back('{2, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b1111, 1'b1});
        ops.push_back('{2, 1'b0, 32'h0,  32'h0, 4'b1111, 1'b1});
        ops.push_back('{2, 1'b0, 32'h3C, 32'h0, 4'b1111, 1'b1});
        ops.push_back('{2, 1'b0, 32'h40, 32'h0, 4'b1111, 1'b1});
        ops.push_back('{2, 1'b1, 32'h44, 32'h0000_9999, 4'b0011, 1'b1});
        ops.push_back('{2, 1'b0, 32'h4,  32'h0, 4'b1111, 1'b1});
        ops.push_back('{2, 1'b0, 32'h0,  32'h0, 4'b1111, 1'b1});
        test_ops("out_of_range", ops);
    endtask

    task automatic test_reset_mid;
        op_t ops[$];
        int  acks;
        ops.push_back('{1, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'b1111, 1'b1});
        test_ops("reset_mid_setup", ops);
        @(posedge clk);
        #1;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h10; wdata[1] = 32'hFFFF_FFFF; sel[1] = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        req[1] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) last_rd[k] = 32'h0;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ack[1] === 1'b1) acks++;
        end
        n_assert++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL reset_mid_ack: %0d acks seen, expected 0", acks);
        end
        ops.delete();
        ops.push_back('{1, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b1});
        test_ops("reset_mid_read", ops);
    endtask

    task automatic test_back_to_back;
        op_t ops[$];
        ops.push_back('{0, 1'b1, 32'h4, 32'h1111_1111, 4'b1111, 1'b0});
        ops.push_back('{0, 1'b1, 32'h8, 32'h2222_2222, 4'b1111, 1'b0});
        ops.push_back('{0, 1'b0, 32'h4, 32'h0, 4'b1111, 1'b0});
        ops.push_back('{0, 1'b0, 32'h8, 32'h0, 4'b1111, 1'b1});
        test_ops("back_to_back", ops);
    endtask

    task automatic test_random;
        op_t ops[$];
        for (int i = 0; i < 8; i++)
            ops.push_back('{0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 4'b1111, 1'b1});
        for (int i = 0; i < 24; i++)
            ops.push_back('{0, 1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 7)),
                            $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))});
        ops[$].rel = 1'b1;
        test_ops("random", ops);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0; sel[k] = '0;
            last_rd[k] = 32'h0;
        end
        test_reset();
        test_full_word();
        test_partial();
        test_wait();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rib_ram_slave.md
RIB_RAM_SLAVE -- requirements
Module: rib_ram_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, meaning the number of 32-bit RAM words; it is a power of two, minimum 16.
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, range 0..15, meaning the wait states inserted before each RAM access.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req_i, input, 1 bit: bus request from the initiator (RIB_REQ=1).
REQ-007 SHALL have port we_i, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port addr_i, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-009 SHALL have port wdata_i, input, 32 bits: write data, already lane-shifted by the initiator.
REQ-010 SHALL have port sel_i, input, 4 bits: byte strobes; bit n enables lane [8n+7:8n].
REQ-011 SHALL have port ack_o, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port rdata_o, output, 32 bits: read data, valid while ack_o=1 on a read.
REQ-013 SHALL have port err_o, output, 1 bit: asserted with ack_o for an out-of-range access.

Function
REQ-014 SHALL implement the FSM IDLE -> WAIT -> ACCESS -> [MERGE] -> RESP -> IDLE; WAIT is skipped when WAIT_CYCLES=0.
REQ-015 In IDLE with req_i=1, SHALL latch we_i, addr_i, wdata_i and sel_i, load the wait counter with WAIT_CYCLES, and leave IDLE.
REQ-016 Initiator SHALL hold req_i and its payload until ack_o; the slave SHALL ignore payload changes after the latch.
REQ-017 In WAIT, SHALL decrement the counter and enter ACCESS when it reaches 1.
REQ-018 In ACCESS, SHALL issue the RAM read, or the RAM write of the latched lanes, at word index addr[log2(DEPTH_WORDS)+1:2].
REQ-019 In RESP, SHALL drive ack_o=1 for exactly one cycle; for reads, rdata_o SHALL carry the full RAM word, and lane extraction is the initiator's job.
REQ-020 Latency from first req_i=1 cycle to ack_o SHALL be WAIT_CYCLES+2 cycles, or WAIT_CYCLES+3 when MERGE is used.
REQ-021 SHALL accept a new request no earlier than the cycle after ack_o; back-to-back requests SHALL be handled with no lost transaction.
REQ-022 When addr_i[31:2] >= DEPTH_WORDS, SHALL perform no RAM write, and SHALL drive ack_o=1, err_o=1 and rdata_o=0 in RESP.
REQ-023 A write with sel_i=4'b0000 SHALL complete with ack_o and leave the RAM unchanged.
REQ-024 rdata_o SHALL hold its last read value between reads and be unchanged by writes.

Reset
REQ-025 rst=1 SHALL force the FSM to IDLE, the wait counter to 0, ack_o=0, err_o=0 and rdata_o=0.
REQ-026 rst asserted mid-transaction SHALL abort it with no ack_o; a RAM write already issued stands, and no MERGE write SHALL occur after reset.
REQ-027 RAM contents SHALL NOT be reset.

Configuration
REQ-028 With macro RIB_RAM_BYTE_WE_EN defined, ACCESS SHALL write the strobed lanes directly using per-byte RAM write enables, and MERGE SHALL never be entered.
REQ-029 Without RIB_RAM_BYTE_WE_EN, a write with sel_i != 4'b1111 and != 0 SHALL read the word in ACCESS, merge the strobed lanes in MERGE, write the whole word, then go to RESP.

Structure
REQ-030 The shared package rib_pkg SHALL hold the FSM state enum, the RIB_REQ/RIB_NREQ constants and the SEL_* strobe constants.
REQ-031 The RAM SHALL be a sub-module, rib_ram_sp: single-port RAM with synchronous 1-cycle read and a 4-bit byte write enable.

Verification
REQ-032 Verification SHALL cover: WAIT_CYCLES=0, write 0x12345678 to 0x40 with sel=1111, then read 0x40 -> ack 2 cycles after each request, rdata_o=0x12345678.
REQ-033 Verification SHALL cover: word 0x40 = 0x12345678, write wdata=0x0000AB00 with sel=0010 -> read returns 0x1234AB78; ack latency 2 cycles with the macro, 3 without.
REQ-034 Verification SHALL cover: WAIT_CYCLES=3, read 0x0 -> ack in cycle 5, single-cycle pulse.
REQ-035 Verification SHALL cover: DEPTH_WORDS=16, write to 0x40 -> ack_o=1, err_o=1, RAM unchanged; read of 0x40 -> rdata_o=0.
REQ-036 Verification SHALL cover: rst pulsed during WAIT of a write -> no ack_o, state IDLE, target word unchanged.
REQ-037 Verification SHALL cover: req_i held high across two back-to-back writes to 0x4 and 0x8 -> two acks, both words written.
